dma_copy_engine: RTL and testbench

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/peripheral_pkg.sv | 26 ++
 rtl/dma_wait_timer.sv | 31 +++
 rtl/dma_copy_engine.sv | 121 ++++++++++++
 tb/tb_dma_copy_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_pkg.sv
// Shared definitions for the peripheral block: DMA engine state encoding and bus word size.
package peripheral_pkg;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_WAIT = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RD_REQ  = ST_RD_REQ,
        RD_WAIT = ST_RD_WAIT,
        WR_REQ  = ST_WR_REQ,
        WR_WAIT = ST_WR_WAIT,
        FIN     = ST_FIN
    } dma_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dma_wait_timer.sv
// Wait-cycle counter for the DMA engine; flags the cycle in which the WAIT_LIMIT-th wait cycle occurs.
module dma_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry is raised on the limit-th waiting cycle so the engine leaves the state on that edge.
    always_comb begin
        expired = count_en && (cnt == CW'(WAIT_LIMIT - 1));
    end

endmodule

// File: rtl/dma_copy_engine.sv
// Single-outstanding word-copy DMA engine: read a word, write it, repeat for len_words words.
module dma_copy_engine
    import peripheral_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len_words,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        aborted,
    output logic [15:0] words_done,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    dma_state_e  state, state_next;
    logic [31:0] src_q, dst_q, data_q;
    logic [15:0] len_q;
    logic        abort_q;
    logic        wait_en, wait_expired, word_ack, last_word, abort_hit;

    dma_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .reload   (state_next != state),
        .count_en (wait_en),
        .expired  (wait_expired)
    );

    always_comb begin
        wait_en   = ((state == RD_REQ  || state == WR_REQ)  && !m_gnt) ||
                    ((state == RD_WAIT || state == WR_WAIT) && !m_rvalid);
        word_ack  = (state == WR_WAIT) && m_rvalid;
        last_word = (words_done + 16'd1) == len_q;
        abort_hit = abort_q || abort;

        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len_words == 16'd0) ? FIN : RD_REQ;
            RD_REQ:  if (wait_expired) state_next = FIN;
                     else if (m_gnt) state_next = RD_WAIT;
            RD_WAIT: if (wait_expired) state_next = FIN;
                     else if (m_rvalid) state_next = WR_REQ;
            WR_REQ:  if (wait_expired) state_next = FIN;
                     else if (m_gnt) state_next = WR_WAIT;
            WR_WAIT: if (wait_expired) state_next = FIN;
                     else if (m_rvalid) state_next = (last_word || abort_hit) ? FIN : RD_REQ;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs decode straight from state so m_req drops the cycle after the grant edge.
    always_comb begin
        busy    = (state == RD_REQ) || (state == RD_WAIT) ||
                  (state == WR_REQ) || (state == WR_WAIT);
        done    = (state == FIN);
        m_req   = (state == RD_REQ) || (state == WR_REQ);
        m_we    = (state == WR_REQ);
        m_be    = m_req ? 4'hF : 4'h0;
        m_addr  = '0;
        m_wdata = '0;
        if (state == RD_REQ) m_addr = src_q;
        if (state == WR_REQ) begin
            m_addr  = dst_q;
            m_wdata = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            len_q      <= '0;
            abort_q    <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
            words_done <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                src_q      <= word_align(src_addr);
                dst_q      <= word_align(dst_addr);
                len_q      <= len_words;
                abort_q    <= 1'b0;
                err        <= 1'b0;
                aborted    <= 1'b0;
                words_done <= '0;
            end else begin
                if (busy && abort) abort_q <= 1'b1;
                if (state == FIN) abort_q <= 1'b0;
                if (state == RD_WAIT && m_rvalid) data_q <= m_rdata;
                if (word_ack) begin
                    words_done <= words_done + 16'd1;
                    src_q      <= src_q + 32'(WORD_BYTES);
                    dst_q      <= dst_q + 32'(WORD_BYTES);
                end
                if (wait_expired) err <= 1'b1;
                if (busy && state_next == FIN && abort_hit) aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: bus responder with a transaction scoreboard.
module tb_dma_copy_engine;

    logic        clk, rst, start, abort;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_words;
    logic        busy, done, err, aborted;
    logic [15:0] words_done;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_gnt, m_rvalid;

    dma_copy_engine #(.WAIT_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len_words(len_words), .abort(abort), .busy(busy), .done(done), .err(err),
        .aborted(aborted), .words_done(words_done), .m_req(m_req), .m_we(m_we),
        .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   req_total = 0;
    int   busy_total = 0;
    int   mode = 0;       // 0 normal, 1 never grant, 2 spurious gnt/rvalid
    int   gnt_delay = 0;
    int   rv_delay = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_req) req_total <= req_total + 1;
        if (busy)  busy_total <= busy_total + 1;
    end

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[7:0], ~a[31:24], a[15:8] ^ 8'h5A, a[23:16]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] sa, da;
        sa = {src[31:2], 2'b00};
        da = {dst[31:2], 2'b00};
        for (int w = 0; w < n; w++) begin
            exp_q.push_back('{we: 1'b0, addr: sa, data: 32'h0});
            exp_q.push_back('{we: 1'b1, addr: da, data: rdata_of(sa)});
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    // Responder acts 2 time units after each rising edge, after the main sequence has driven.
    initial begin : responder
        int          req_age;
        int          rv_cnt;
        bit          pending;
        logic        hold_we, rd_we;
        logic [31:0] hold_addr, hold_wdata, rd_addr;
        txn_t        t;
        req_age = 0; rv_cnt = 0; pending = 0;
        hold_we = 0; hold_addr = 0; hold_wdata = 0; rd_we = 0; rd_addr = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        forever begin
            @(posedge clk);
            #2;
            m_gnt = 1'b0;
            m_rvalid = 1'b0;
            m_rdata = $urandom();
            if (mode == 2) begin
                m_gnt = 1'b1;
                m_rvalid = 1'b1;
            end else if (!busy) begin
                pending = 0;
                req_age = 0;
            end else if (pending) begin
                check("one_outstanding", m_req, 1'b0);
                if (rv_cnt == 0) begin
                    m_rvalid = 1'b1;
                    if (!rd_we) m_rdata = rdata_of(rd_addr);
                    pending = 0;
                end else begin
                    rv_cnt--;
                end
            end else if (m_req) begin
                check("be_full", m_be, 4'hF);
                if (req_age == 0) begin
                    hold_we = m_we; hold_addr = m_addr; hold_wdata = m_wdata;
                end else begin
                    check("req_stable", {m_we, m_addr, m_wdata}, {hold_we, hold_addr, hold_wdata});
                end
                if (mode == 0 && req_age >= 1 + gnt_delay) begin
                    m_gnt = 1'b1;
                    check("sb_nonempty", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        check("txn_we", m_we, t.we);
                        check("txn_addr", m_addr, t.addr);
                        if (t.we) check("txn_wdata", m_wdata, t.data);
                    end
                    pending = 1;
                    rv_cnt = rv_delay;
                    rd_addr = m_addr;
                    rd_we = m_we;
                    req_age = 0;
                end else begin
                    req_age++;
                end
            end
        end
    end

    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input int n_push, input int exp_lat,
                            input int exp_words, input logic exp_err, input logic exp_abt,
                            input int abort_at, input int restart_at,
                            output int req_n, output int busy_n);
        int s, lat, req0, busy0;
        push_words(src, dst, n_push);
        req0 = req_total;
        busy0 = busy_total;
        src_addr = src; dst_addr = dst; len_words = len;
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                lat = cyc - s;
                break;
            end
            abort = (cyc - s == abort_at);
            if (cyc - s == restart_at) begin
                start = 1'b1;
                src_addr = 32'hDEAD_0000;
                len_words = 16'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        abort = 1'b0;
        start = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_words_done"}, words_done, exp_words);
        check({name, "_err"}, err, exp_err);
        check({name, "_aborted"}, aborted, exp_abt);
        check({name, "_busy_in_fin"}, busy, 1'b0);
        check({name, "_req_in_fin"}, m_req, 1'b0);
        step();
        check({name, "_done_one_cycle"}, done, 1'b0);
        check({name, "_sb_drained"}, exp_q.size(), 0);
        req_n = req_total - req0;
        busy_n = busy_total - busy0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {busy, done, err, aborted, m_req, m_we}, 6'b0);
        check({name, "_bus"}, {m_be, m_addr, m_wdata}, 68'h0);
        check({name, "_words_done"}, words_done, 16'h0);
    endtask

    initial begin : main
        int req_n, busy_n;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        run_copy("zero_wait", 32'h0002_0000, 32'h0002_1000, 16'd3, 3, 19, 3, 1'b0, 1'b0, -1, -1,
                 req_n, busy_n);
        check("zero_wait_busy_cycles", busy_n, 18);

        run_copy("len0", 32'h0000_1000, 32'h0000_2000, 16'd0, 0, 1, 0, 1'b0, 1'b0, -1, -1,
                 req_n, busy_n);
        check("len0_no_req", req_n, 0);
        check("len0_no_busy", busy_n, 0);

        gnt_delay = 5; rv_delay = 3;
        run_copy("delayed", 32'h0000_0100, 32'h0000_0200, 16'd2, 2, 45, 2, 1'b0, 1'b0, -1, -1,
                 req_n, busy_n);
        check("delayed_req_cycles", req_n, 28);
        gnt_delay = 0; rv_delay = 0;

        run_copy("abort", 32'h0000_3000, 32'h0000_4000, 16'd4, 2, 13, 2, 1'b0, 1'b1, 8, -1,
                 req_n, busy_n);

        mode = 1;
        run_copy("timeout", 32'h0000_5000, 32'h0000_6000, 16'd1, 0, 9, 0, 1'b1, 1'b0, -1, -1,
                 req_n, busy_n);
        check("timeout_req_cycles", req_n, 8);
        mode = 0;

        run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_0503, 16'd2, 2, 13, 2, 1'b0, 1'b0, -1, 5,
                 req_n, busy_n);

        mode = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spurious_idle", {busy, done, m_req}, 3'b0);
        end
        mode = 0;
        step();

        // Reset lands on the grant edge of word 1's read, leaving that read outstanding.
        exp_q.push_back('{we: 1'b0, addr: 32'h0000_0600, data: 32'h0});
        exp_q.push_back('{we: 1'b1, addr: 32'h0000_0700, data: rdata_of(32'h0000_0600)});
        exp_q.push_back('{we: 1'b0, addr: 32'h0000_0604, data: 32'h0});
        src_addr = 32'h0000_0600; dst_addr = 32'h0000_0700; len_words = 16'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("midcopy_words_before_reset", words_done, 16'd1);
        rst = 1'b0;
        step();
        check_reset_outputs("midcopy_reset");
        step();
        check_reset_outputs("midcopy_reset_hold");
        rst = 1'b1;
        step();
        check("midcopy_idle_after", {busy, m_req}, 2'b0);
        check("midcopy_sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
